// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: streams DDR beats into the weight-buffer banks and launches kernel reads
// for tiles that are fully resident. Define WLC_PERF_CNT_EN to add stall/read-wait counters.
module weight_load_ctrl #(
    parameter int X_PE         = 16,
    parameter int X_MESH       = 16,
    parameter int ADDR_LEN     = 16,
    parameter int DATA_LEN     = 64,
    parameter int DDR_DATA_LEN = 256,
    parameter int TILE_W       = 8,
    parameter int TAPS         = 9,
    parameter int BUFFER_NUM   = 8 * X_PE * X_MESH / DATA_LEN,
    parameter int LANES        = DDR_DATA_LEN / DATA_LEN,
    parameter int GROUPS       = BUFFER_NUM / LANES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_LEN-1:0]     cmd_base,
    input  logic [TILE_W-1:0]       cmd_tiles,
    input  logic [DDR_DATA_LEN-1:0] ddr_data,
    input  logic                    ddr_valid,
    output logic                    ddr_ready,
    output logic [DDR_DATA_LEN-1:0] wb_data_wr,
    output logic [ADDR_LEN-1:0]     wb_wr_addr,
    output logic [BUFFER_NUM-1:0]   wb_wr_en,
    input  logic                    rd_req_valid,
    input  logic [TILE_W-1:0]       rd_req_tile,
    output logic                    rd_req_ready,
    output logic                    wb_rd_conf,
    output logic [ADDR_LEN-1:0]     wb_st_rd_addr,
    input  logic                    wb_idle,
    input  logic                    wb_ker_en,
    output logic                    load_done,
    output logic                    err_tile
`ifdef WLC_PERF_CNT_EN
    ,
    output logic [31:0]             stall_cycles,
    output logic [31:0]             rd_wait_cycles
`endif
);

    localparam int G_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int W_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [BUFFER_NUM-1:0] LANE_MASK = BUFFER_NUM'((1 << LANES) - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t              state;
    logic [ADDR_LEN-1:0] base;
    logic [ADDR_LEN-1:0] row_addr;
    logic [TILE_W-1:0]   tiles;
    logic [TILE_W-1:0]   tiles_loaded;
    logic [G_W-1:0]      g_cnt;
    logic [W_W-1:0]      w_cnt;
    logic                inflight;
    logic                cmd_fire;
    logic                beat;
    logic                rd_accept;
    logic                rd_err;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign beat     = ddr_valid && ddr_ready;

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        rd_accept    = rd_req_valid && !inflight && wb_idle && (rd_req_tile < tiles_loaded);
        rd_err       = rd_req_valid && (rd_req_tile >= tiles);
        rd_req_ready = rd_accept || rd_err;
    end

    // NOTE: state is updated with non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cmd_ready     <= 1'b1;
            ddr_ready     <= 1'b0;
            wb_data_wr    <= '0;
            wb_wr_addr    <= '0;
            wb_wr_en      <= '0;
            wb_rd_conf    <= 1'b0;
            wb_st_rd_addr <= '0;
            load_done     <= 1'b0;
            err_tile      <= 1'b0;
            base          <= '0;
            row_addr      <= '0;
            tiles         <= '0;
            tiles_loaded  <= '0;
            g_cnt         <= '0;
            w_cnt         <= '0;
            inflight      <= 1'b0;
        end else begin
            wb_wr_en   <= '0;
            load_done  <= 1'b0;
            wb_rd_conf <= 1'b0;
            err_tile   <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        base         <= cmd_base;
                        row_addr     <= cmd_base;
                        tiles        <= cmd_tiles;
                        tiles_loaded <= '0;
                        g_cnt        <= '0;
                        w_cnt        <= '0;
                        if (cmd_tiles == '0) begin
                            load_done <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            cmd_ready <= 1'b0;
                            ddr_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (beat) begin
                        wb_data_wr <= ddr_data;
                        wb_wr_addr <= row_addr;
                        wb_wr_en   <= LANE_MASK << (int'(g_cnt) * LANES);
                        if (g_cnt == G_W'(GROUPS - 1)) begin
                            // Word rows are contiguous across tiles, so the row address just counts up.
                            g_cnt    <= '0;
                            row_addr <= row_addr + ADDR_LEN'(1);
                            if (w_cnt == W_W'(TAPS - 1)) begin
                                w_cnt        <= '0;
                                tiles_loaded <= tiles_loaded + TILE_W'(1);
                                if (tiles_loaded == tiles - TILE_W'(1)) begin
                                    state     <= IDLE;
                                    load_done <= 1'b1;
                                    cmd_ready <= 1'b1;
                                    ddr_ready <= 1'b0;
                                end
                            end else begin
                                w_cnt <= w_cnt + W_W'(1);
                            end
                        end else begin
                            g_cnt <= g_cnt + G_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (rd_accept) begin
                wb_rd_conf    <= 1'b1;
                wb_st_rd_addr <= base + ADDR_LEN'(rd_req_tile) * ADDR_LEN'(TAPS);
                inflight      <= 1'b1;
            end else if (wb_ker_en) begin
                inflight <= 1'b0;
            end

            if (rd_err) begin
                err_tile <= 1'b1;
            end
        end
    end

`ifdef WLC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || cmd_fire) begin
            stall_cycles   <= '0;
            rd_wait_cycles <= '0;
        end else begin
            if (state == LOAD && !ddr_valid && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (rd_req_valid && !rd_req_ready && rd_wait_cycles != '1) begin
                rd_wait_cycles <= rd_wait_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
